// File: rtl/instruction_fetch_ctrl_if.sv
// Fetch-to-decode handshake: {pc, instruction} pairs offered with valid/ready.
interface instruction_fetch_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;

  modport master (output out_valid, output out_inst, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_inst, input out_pc, output out_ready);
endinterface

// File: rtl/instruction_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads a single-cycle instruction memory and queues
// {pc, instruction} pairs for decode; redirects flush and reload, ebreak halts fetch.
module instruction_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [63:0]                    Inst_Addr,
  input  logic [31:0]                    Instruction,
  input  logic                           fetch_en,
  input  logic                           redirect_valid,
  input  logic [63:0]                    redirect_pc,
  instruction_fetch_ctrl_if.master       out_if,
  output logic                           halted
);

  localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW     = AW + 1;
  localparam logic [31:0] EBREAK = 32'h00100073;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t        state;
  logic [63:0]   pc;
  logic [63:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          is_ebreak;

  // Fullness is judged on the pre-pop count, so a full queue never pushes even while draining.
  assign push      = (state == FETCH) && fetch_en && !redirect_valid && (count < CW'(DEPTH));
  assign pop       = out_if.out_valid && out_if.out_ready && !redirect_valid;
  assign is_ebreak = (Instruction == EBREAK);

  assign Inst_Addr        = pc;
  assign out_if.out_valid = (count != '0);
  assign out_if.out_inst  = out_if.out_valid ? fifo_inst[rd_ptr] : 32'h0;
  assign out_if.out_pc    = out_if.out_valid ? fifo_pc[rd_ptr]   : 64'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      halted <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc & ~64'h3;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      halted <= 1'b0;
      state  <= fetch_en ? FETCH : IDLE;
    end else begin
      // The ebreak word is queued but the PC parks on its address.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!is_ebreak) pc <= pc + 64'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case (state)
        IDLE:    if (fetch_en) state <= FETCH;
        FETCH: begin
          if (!fetch_en) begin
            state <= IDLE;
          end else if (push && is_ebreak) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT:    ;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= pc;
      fifo_inst[wr_ptr] <= Instruction;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Scoreboard bench for instruction_fetch_ctrl: directed scenarios push expected
// {pc, inst} entries, a negedge monitor pops and compares each accepted output.
module tb_instruction_fetch_ctrl;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] inst_addr;
  logic [31:0] instruction;
  logic        fetch_en;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;
  logic [63:0] ebreak_at;

  logic [63:0] inst_addr_w;
  logic [31:0] instruction_w;
  logic        fetch_en_w;
  logic        halted_w;

  entry_t sb[$];
  int     checks = 0;
  int     errors = 0;

  instruction_fetch_ctrl_if dec_if ();
  instruction_fetch_ctrl_if wrap_if ();

  instruction_fetch_ctrl #(.RESET_PC(64'h0), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .Inst_Addr      (inst_addr),
    .Instruction    (instruction),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_if         (dec_if),
    .halted         (halted)
  );

  instruction_fetch_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DEPTH(2)) u_wrap (
    .clk            (clk),
    .reset          (reset),
    .Inst_Addr      (inst_addr_w),
    .Instruction    (instruction_w),
    .fetch_en       (fetch_en_w),
    .redirect_valid (1'b0),
    .redirect_pc    (64'h0),
    .out_if         (wrap_if),
    .halted         (halted_w)
  );

  always #5 clk = ~clk;

  // Instruction memory: three fixed words at the bottom, addi-like filler elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a, input logic [63:0] brk);
    if (a == brk) return 32'h00100073;
    case (a)
      64'h0:   return 32'h00500093;
      64'h4:   return 32'h00A00113;
      64'h8:   return 32'h002081B3;
      default: return {a[11:0], 20'h00013};
    endcase
  endfunction

  always_comb instruction   = mem_word(inst_addr, ebreak_at);
  always_comb instruction_w = mem_word(inst_addr_w, 64'hFFFF_FFFF_FFFF_FFF0);

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [63:0] pc, input logic [31:0] inst);
    entry_t e;
    e.pc   = pc;
    e.inst = inst;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic rdy);
    fetch_en         = en;
    dec_if.out_ready = rdy;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #2;
    reset          = 1'b0;
    fetch_en       = 1'b0;
    fetch_en_w     = 1'b0;
    redirect_valid = 1'b0;
    dec_if.out_ready = 1'b0;
    sb.delete();
    #4;
    reset = 1'b1;
  endtask

  // Monitor: every accepted head entry must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && dec_if.out_valid && dec_if.out_ready && !redirect_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_entry actual pc=%h inst=%h expected none",
                 dec_if.out_pc, dec_if.out_inst);
      end else begin
        entry_t e;
        e = sb.pop_front();
        if (dec_if.out_pc !== e.pc || dec_if.out_inst !== e.inst) begin
          errors++;
          $display("[TB] FAIL entry actual pc=%h inst=%h expected pc=%h inst=%h",
                   dec_if.out_pc, dec_if.out_inst, e.pc, e.inst);
        end
      end
    end
  end

  initial begin
    fetch_en          = 1'b0;
    fetch_en_w        = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 64'h0;
    dec_if.out_ready  = 1'b0;
    wrap_if.out_ready = 1'b0;
    ebreak_at         = '1;

    // Reset values before any clock edge
    #1 reset = 1'b0;
    #2;
    check_output("rst_inst_addr", inst_addr, 64'h0);
    check_output("rst_out_valid", 64'(dec_if.out_valid), 64'h0);
    check_output("rst_out_inst", 64'(dec_if.out_inst), 64'h0);
    check_output("rst_out_pc", dec_if.out_pc, 64'h0);
    check_output("rst_halted", 64'(halted), 64'h0);
    check_output("rst_wrap_inst_addr", inst_addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
    check_output("rst_wrap_halted", 64'(halted_w), 64'h0);

    // Streaming after reset release, then fetch_en drop and resume
    do_reset;
    apply_stimulus(1'b1, 1'b1);
    expect_entry(64'h0, 32'h00500093);
    expect_entry(64'h4, 32'h00A00113);
    expect_entry(64'h8, 32'h002081B3);
    tick; check_output("s1_addr_e1", inst_addr, 64'h0);
    check_output("s1_valid_e1", 64'(dec_if.out_valid), 64'h0);
    tick; check_output("s1_addr_e2", inst_addr, 64'h4);
    tick; check_output("s1_addr_e3", inst_addr, 64'h8);
    tick; check_output("s1_addr_e4", inst_addr, 64'hC);
    apply_stimulus(1'b0, 1'b1);
    tick; check_output("s1_addr_frozen", inst_addr, 64'hC);
    tick; tick; tick;
    check_output("s1_addr_frozen_late", inst_addr, 64'hC);
    check_output("s1_valid_idle", 64'(dec_if.out_valid), 64'h0);
    check_output("s1_sb_drained", 64'(sb.size()), 64'h0);
    expect_entry(64'hC,  32'h00C00013);
    expect_entry(64'h10, 32'h01000013);
    expect_entry(64'h14, 32'h01400013);
    apply_stimulus(1'b1, 1'b1);
    tick; check_output("s5_addr_e1", inst_addr, 64'hC);
    tick; check_output("s5_addr_e2", inst_addr, 64'h10);
    tick; check_output("s5_addr_e3", inst_addr, 64'h14);
    tick; check_output("s5_addr_e4", inst_addr, 64'h18);
    apply_stimulus(1'b0, 1'b1);
    tick; tick;
    check_output("s5_sb_drained", 64'(sb.size()), 64'h0);

    // Backpressure: FIFO fills to DEPTH, then drains in order
    do_reset;
    apply_stimulus(1'b1, 1'b0);
    expect_entry(64'h0, 32'h00500093);
    expect_entry(64'h4, 32'h00A00113);
    expect_entry(64'h8, 32'h002081B3);
    repeat (6) tick;
    check_output("bp_addr_hold", inst_addr, 64'h8);
    check_output("bp_valid", 64'(dec_if.out_valid), 64'h1);
    check_output("bp_head_pc", dec_if.out_pc, 64'h0);
    check_output("bp_head_inst", 64'(dec_if.out_inst), 64'h00500093);
    apply_stimulus(1'b1, 1'b1);
    tick; check_output("bp_addr_full_pop", inst_addr, 64'h8);
    tick; check_output("bp_addr_resume", inst_addr, 64'hC);
    apply_stimulus(1'b0, 1'b1);
    tick; tick;
    check_output("bp_sb_drained", 64'(sb.size()), 64'h0);
    check_output("bp_valid_empty", 64'(dec_if.out_valid), 64'h0);

    // Redirect with a full queue, then a misaligned target
    do_reset;
    apply_stimulus(1'b1, 1'b0);
    repeat (3) tick;
    check_output("rd_full_valid", 64'(dec_if.out_valid), 64'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    tick;
    redirect_valid = 1'b0;
    check_output("rd_flush_valid", 64'(dec_if.out_valid), 64'h0);
    check_output("rd_addr_target", inst_addr, 64'h40);
    apply_stimulus(1'b1, 1'b1);
    expect_entry(64'h40, 32'h04000013);
    expect_entry(64'h44, 32'h04400013);
    tick;
    check_output("rd_addr_44", inst_addr, 64'h44);
    check_output("rd_head_pc", dec_if.out_pc, 64'h40);
    tick; check_output("rd_addr_48", inst_addr, 64'h48);
    apply_stimulus(1'b0, 1'b1);
    tick;
    check_output("rd_sb_drained", 64'(sb.size()), 64'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h43;
    apply_stimulus(1'b1, 1'b1);
    tick;
    redirect_valid = 1'b0;
    check_output("rd43_addr", inst_addr, 64'h40);
    expect_entry(64'h40, 32'h04000013);
    expect_entry(64'h44, 32'h04400013);
    tick; check_output("rd43_addr_44", inst_addr, 64'h44);
    tick; check_output("rd43_addr_48", inst_addr, 64'h48);
    apply_stimulus(1'b0, 1'b1);
    tick; tick;
    check_output("rd43_sb_drained", 64'(sb.size()), 64'h0);

    // ebreak halts with PC parked, redirect resumes
    ebreak_at = 64'hC;
    do_reset;
    apply_stimulus(1'b1, 1'b1);
    expect_entry(64'h0, 32'h00500093);
    expect_entry(64'h4, 32'h00A00113);
    expect_entry(64'h8, 32'h002081B3);
    expect_entry(64'hC, 32'h00100073);
    repeat (4) tick;
    check_output("eb_halted_before", 64'(halted), 64'h0);
    tick;
    check_output("eb_halted", 64'(halted), 64'h1);
    check_output("eb_addr_park", inst_addr, 64'hC);
    repeat (10) tick;
    check_output("eb_addr_park_late", inst_addr, 64'hC);
    check_output("eb_halted_late", 64'(halted), 64'h1);
    check_output("eb_sb_drained", 64'(sb.size()), 64'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    tick;
    redirect_valid = 1'b0;
    check_output("eb_halted_clear", 64'(halted), 64'h0);
    check_output("eb_redirect_addr", inst_addr, 64'h0);
    expect_entry(64'h0, 32'h00500093);
    tick; check_output("eb_resume_addr", inst_addr, 64'h4);
    apply_stimulus(1'b0, 1'b1);
    tick; tick;
    check_output("eb_resume_drained", 64'(sb.size()), 64'h0);
    ebreak_at = '1;

    // Asynchronous reset between edges with a full FIFO
    do_reset;
    apply_stimulus(1'b1, 1'b0);
    repeat (3) tick;
    check_output("ar_full_valid", 64'(dec_if.out_valid), 64'h1);
    #3 reset = 1'b0;
    #1;
    check_output("ar_inst_addr", inst_addr, 64'h0);
    check_output("ar_out_valid", 64'(dec_if.out_valid), 64'h0);
    check_output("ar_out_pc", dec_if.out_pc, 64'h0);
    check_output("ar_out_inst", 64'(dec_if.out_inst), 64'h0);
    check_output("ar_halted", 64'(halted), 64'h0);
    dec_if.out_ready = 1'b1;
    expect_entry(64'h0, 32'h00500093);
    expect_entry(64'h4, 32'h00A00113);
    #1 reset = 1'b1;
    tick; check_output("ar_addr_e1", inst_addr, 64'h0);
    tick; check_output("ar_addr_e2", inst_addr, 64'h4);
    tick; check_output("ar_addr_e3", inst_addr, 64'h8);
    apply_stimulus(1'b0, 1'b1);
    tick; tick;
    check_output("ar_sb_drained", 64'(sb.size()), 64'h0);

    // PC wrap from the top of the address space
    do_reset;
    fetch_en_w = 1'b1;
    tick; check_output("wrap_addr_e1", inst_addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
    tick;
    check_output("wrap_addr_e2", inst_addr_w, 64'h0);
    check_output("wrap_valid", 64'(wrap_if.out_valid), 64'h1);
    check_output("wrap_head_pc", wrap_if.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_output("wrap_head_inst", 64'(wrap_if.out_inst), 64'hFFC00013);
    fetch_en_w = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_ctrl.md
# instruction_fetch_ctrl

Fetch sequencer for the single-cycle-read `Instruction_Memory`. It owns the 64-bit program counter and drives `Inst_Addr`. It captures the returned 32-bit `Instruction` into a small FIFO and presents `{pc, instruction}` pairs to decode over a valid/ready handshake. Branch redirects flush the queue and reload the PC; fetch stops at `ebreak`.

## Interface
- `RESET_PC`, default 64'h0: PC loaded on reset; low 2 bits must be 0.
- `DEPTH`, default 2: fetch FIFO entries; power of two, ≥2.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `Inst_Addr` output 64: address to `Instruction_Memory`, equals PC register.
- `Instruction` input 32: combinational read data for `Inst_Addr`.
- `fetch_en` input 1: permit fetching.
- `redirect_valid` input 1: load new PC and flush, one-cycle pulse.
- `redirect_pc` input 64: redirect target; bits [1:0] ignored, forced 0.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: decode accepts head.
- `out_inst` output 32: head instruction, 0 when empty.
- `out_pc` output 64: head PC, 0 when empty.
- `halted` output 1: high in HALT state.

## Operation
- States: IDLE, FETCH, HALT. Reset → IDLE.
- IDLE → FETCH when `fetch_en`=1. No push occurs in IDLE.
- FETCH → IDLE when `fetch_en`=0. No push in that cycle.
- FETCH → HALT when a pushed `Instruction` equals 32'h00100073 (`ebreak`). The `ebreak` itself is enqueued. PC stays at the `ebreak` address.
- HALT exits only on redirect or reset. With redirect it goes to FETCH if `fetch_en`=1, else IDLE.
- Push condition: state FETCH, `fetch_en`=1, `redirect_valid`=0, and count < DEPTH, where count is evaluated before this cycle's pop.
  - On push: write `{PC, Instruction}` at the tail and set PC ← PC+4.
  - Otherwise PC holds.
- Pop on `out_valid` && `out_ready`.
- Push and pop in the same cycle give count unchanged. When full, no push occurs even if a pop happens that cycle.
- Redirect has the highest priority in any state:
  - PC ← {`redirect_pc`[63:2], 2'b00}.
  - FIFO count ← 0 and pointers ← 0.
  - No push and no pop is counted.
  - `halted` clears.
- PC arithmetic is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- FIFO uses wrapping pointers with log2(DEPTH) bits and a separate count of log2(DEPTH)+1 bits.

## Timing
- Reset values (asynchronous, taken immediately on `reset`=0):
  - PC/`Inst_Addr` = `RESET_PC`.
  - State IDLE.
  - `out_valid`=0, `out_inst`=0, `out_pc`=0, `halted`=0.
  - FIFO empty.
- Reset asserted mid-operation discards all queued entries and the state.
- `Inst_Addr` is a register output, and `Instruction` is sampled at the same edge that advances PC.
- Latency: `fetch_en` rises in cycle 0 → IDLE→FETCH at edge 1 → first push at edge 2 → `out_valid`=1 after edge 2.
- Steady state with `out_ready`=1: one instruction per cycle, PC advances by 4 every cycle.
- Redirect asserted at edge N: `out_valid`=0 after edge N. `Inst_Addr`=target after edge N. First redirected entry is visible after edge N+1 if fetching.
- `out_valid`, `out_inst` and `out_pc` depend only on FIFO state (registered), never combinationally on `Instruction` or `out_ready`.
- `halted` rises the cycle after the `ebreak` push edge.

## Test plan
- Reset release with `fetch_en`=1, memory words 0x00500093, 0x00A00113, 0x002081B3, `out_ready`=1 → `out_pc` 0, 4, 8 on consecutive cycles with matching `out_inst`; `Inst_Addr` steps 0, 4, 8, 12.
- Backpressure: `out_ready`=0 for 5 cycles → exactly DEPTH=2 entries (pc 0, 4) queued, `Inst_Addr` holds 8. Raising `out_ready` drains pc 0, 4, 8 in order with no loss or duplicate.
- Redirect to 64'h40 while 2 entries are queued → next cycle `out_valid`=0. Then `out_pc`=0x40 and `Inst_Addr` walks 0x44, 0x48. `redirect_pc`=0x43 behaves as 0x40.
- `ebreak` at pc 12 → entry (12, 0x00100073) is delivered, `halted`=1, `Inst_Addr` stays 12 for 10 cycles. Redirect to 0 → `halted`=0 and fetch resumes at 0.
- `fetch_en` dropped mid-stream → no further pushes and PC frozen; re-raise → fetch resumes at the frozen PC with no gap or duplicate.
- Async reset pulse mid-fetch, between clock edges, with a full FIFO → outputs reach reset values without waiting for a clock edge. After release, fetch restarts from `RESET_PC`. Also check the wrap case: `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC gives next `Inst_Addr`=0.
